// File: rtl/reg_write_queue_pkg.sv
// Shared definitions for the register-file write queue: default widths, the
// hardwired-zero register number and the {addr,data} write-entry layout.
package reg_write_queue_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         DATA_W_DEF = 32;
  localparam int         ADDR_W_DEF = 5;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } write_entry_t;

endpackage

// File: rtl/reg_write_fifo.sv
// Circular buffer of pending register writes with head/tail pointers and an
// occupancy count; the whole storage is exported flat for the forwarding search.
module reg_write_fifo
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ADDR_W_DEF + DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head_data,
  output logic [PTR_W-1:0]   head_ptr,
  output logic [CNT_W-1:0]   count,
  output logic [DEPTH*W-1:0] entries
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage is deliberately not reset; count and pointers alone decide
  // which slots are meaningful, and stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= push_data;
    end
  end

  // Flush and reset win over any push/pop presented in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*W +: W] = mem[i];
    end
  end

  assign head_data = mem[head_q];
  assign head_ptr  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/reg_write_queue.sv
// Write-side feeder for the register file: queues results, drains one per
// cycle into a registered write port, and forwards pending values to readers.
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InRegister,
  input  logic [DATA_W-1:0] InData,
  input  logic              DrainEn,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] LookupReg1,
  input  logic [ADDR_W-1:0] LookupReg2,
  output logic              LookupHit1,
  output logic              LookupHit2,
  output logic [DATA_W-1:0] LookupData1,
  output logic [DATA_W-1:0] LookupData2,
  output logic [CNT_W-1:0]  Count
);

  localparam int W     = ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);

  logic               push;
  logic               pop;
  logic [W-1:0]       head_data;
  logic [PTR_W-1:0]   head_ptr;
  logic [CNT_W-1:0]   count;
  logic [DEPTH*W-1:0] entries;

  // Full queue never accepts, even if the head drains in the same cycle.
  assign InReady = (count != CNT_W'(DEPTH)) && Rst_n;
  // Writes to the hardwired-zero register complete the handshake but are dropped.
  assign push    = InValid && InReady && (InRegister != ADDR_W'(REG_ZERO));
  assign pop     = DrainEn && (count != '0);
  assign Count   = count;

  reg_write_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .flush     (Flush),
    .push      (push),
    .push_data ({InRegister, InData}),
    .pop       (pop),
    .head_data (head_data),
    .head_ptr  (head_ptr),
    .count     (count),
    .entries   (entries)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (Flush) begin
      RegWrite <= 1'b0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        {WriteRegister, WriteData} <= head_data;
      end
    end
  end

  // Returns {hit, data}; queue entries are scanned oldest to youngest so the
  // last match (tail-most) overrides the output stage and older entries.
  function automatic logic [DATA_W:0] search(
    input logic [ADDR_W-1:0]  query,
    input logic               out_valid,
    input logic [ADDR_W-1:0]  out_addr,
    input logic [DATA_W-1:0]  out_data,
    input logic [DEPTH*W-1:0] ents,
    input logic [PTR_W-1:0]   head,
    input logic [CNT_W-1:0]   cnt
  );
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;
    logic [W-1:0]      ent;
    hit  = 1'b0;
    data = '0;
    if (query != ADDR_W'(REG_ZERO)) begin
      if (out_valid && (out_addr == query)) begin
        hit  = 1'b1;
        data = out_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        ent = ents[idx*W +: W];
        if ((CNT_W'(i) < cnt) && (ent[W-1 -: ADDR_W] == query)) begin
          hit  = 1'b1;
          data = ent[DATA_W-1:0];
        end
      end
    end
    return {hit, data};
  endfunction

  assign {LookupHit1, LookupData1} =
    search(LookupReg1, RegWrite, WriteRegister, WriteData, entries, head_ptr, count);
  assign {LookupHit2, LookupData2} =
    search(LookupReg2, RegWrite, WriteRegister, WriteData, entries, head_ptr, count);

endmodule

// File: tb/tb_reg_write_queue.sv
// Bench for reg_write_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_reg_write_queue;
  import reg_write_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Rst_n, Flush, InValid, DrainEn;
  logic [4:0]       InRegister, LookupReg1, LookupReg2;
  logic [31:0]      InData;
  logic             InReady, RegWrite, LookupHit1, LookupHit2;
  logic [4:0]       WriteRegister;
  logic [31:0]      WriteData, LookupData1, LookupData2;
  logic [CNT_W-1:0] Count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  write_entry_t mq[$];
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  // Register file driven by the DUT write port
  logic [31:0] rf [32];

  reg_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Flush         (Flush),
    .InValid       (InValid),
    .InReady       (InReady),
    .InRegister    (InRegister),
    .InData        (InData),
    .DrainEn       (DrainEn),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .LookupReg1    (LookupReg1),
    .LookupReg2    (LookupReg2),
    .LookupHit1    (LookupHit1),
    .LookupHit2    (LookupHit2),
    .LookupData1   (LookupData1),
    .LookupData2   (LookupData2),
    .Count         (Count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (RegWrite) rf[WriteRegister] <= WriteData;
  end

  function automatic void model_lookup(input logic [4:0] r, output logic hit,
                                       output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 5'd0) begin
      if (m_rw && m_wr == r) begin
        hit = 1'b1;
        d   = m_wd;
      end
      foreach (mq[i]) begin
        if (mq[i].addr == r) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
    end
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    bit           ready;
    write_entry_t h;
    ready = (mq.size() != DEPTH) && Rst_n;
    if (!Rst_n) begin
      mq.delete();
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else if (Flush) begin
      mq.delete();
      m_rw = 1'b0;
    end else begin
      m_rw = DrainEn && (mq.size() != 0);
      if (m_rw) begin
        h    = mq.pop_front();
        m_wr = h.addr;
        m_wd = h.data;
      end
      if (InValid && ready && InRegister != 5'd0) begin
        h.addr = InRegister;
        h.data = InData;
        mq.push_back(h);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Flush = 0; InValid = 0; DrainEn = 0;
    InRegister = '0; InData = '0; LookupReg1 = '0; LookupReg2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst_n = 0;
    tick();
    tick();
    n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL reset_regwrite: got %0b expected 0", RegWrite); end
    n_checks++; if (Count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    n_checks++; if (InReady !== 1'b0) begin n_errors++; $display("FAIL reset_inready_low: got %0b expected 0", InReady); end
    n_checks++; if (WriteData !== '0) begin n_errors++; $display("FAIL reset_wdata: got %0d expected 0", WriteData); end
    Rst_n = 1;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_errors++; $display("FAIL reset_inready_release: got %0b expected 1", InReady); end
  endtask

  task automatic test_single_write();
    InValid = 1; InRegister = 5'd16; InData = 32'd2467; DrainEn = 1;
    tick();
    InValid = 0;
    n_checks++; if (Count !== 3'd1 || RegWrite !== 1'b0) begin n_errors++; $display("FAIL single_accept: got count=%0d rw=%0b expected count=1 rw=0", Count, RegWrite); end
    tick();
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd16 || WriteData !== 32'd2467) begin
      n_errors++; $display("FAIL single_drain: got rw=%0b reg=%0d data=%0d expected rw=1 reg=16 data=2467", RegWrite, WriteRegister, WriteData); end
    n_checks++; if (Count !== '0) begin n_errors++; $display("FAIL single_count: got %0d expected 0", Count); end
    tick();
    n_checks++; if (rf[16] !== 32'd2467) begin n_errors++; $display("FAIL single_regfile: got %0d expected 2467", rf[16]); end
    n_checks++; if (RegWrite !== 1'b0) begin n_errors++; $display("FAIL single_rw_drop: got %0b expected 0", RegWrite); end
    DrainEn = 0;
  endtask

  task automatic test_fill_backpressure();
    DrainEn = 0;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1; InRegister = 5'(i); InData = 32'(10 * i);
      tick();
    end
    InRegister = 5'd7; InData = 32'd70;
    #1;
    n_checks++; if (Count !== 3'd4 || InReady !== 1'b0) begin n_errors++; $display("FAIL fill_full: got count=%0d ready=%0b expected count=4 ready=0", Count, InReady); end
    tick();
    n_checks++; if (Count !== 3'd4) begin n_errors++; $display("FAIL fill_stall: got %0d expected 4", Count); end
    DrainEn = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!InReady) ; else if (k >= 2) InValid = 0;
      n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(k) || WriteData !== 32'(10 * k)) begin
        n_errors++; $display("FAIL fill_order_%0d: got rw=%0b reg=%0d data=%0d expected rw=1 reg=%0d data=%0d", k, RegWrite, WriteRegister, WriteData, k, 10 * k); end
    end
    InValid = 0;
    tick();
    n_checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'd70) begin
      n_errors++; $display("FAIL fill_stalled_push: got rw=%0b reg=%0d data=%0d expected rw=1 reg=7 data=70", RegWrite, WriteRegister, WriteData); end
    n_checks++; if (Count !== int'(mq.size())) begin n_errors++; $display("FAIL fill_count_end: got %0d expected %0d", Count, mq.size()); end
    tick();
    DrainEn = 0;
  endtask

  task automatic test_forwarding();
    DrainEn = 0;
    InValid = 1; InRegister = 5'd5; InData = 32'd7; tick();
    InData = 32'd9; tick();
    InValid = 0; LookupReg1 = 5'd5; LookupReg2 = 5'd6;
    #1;
    n_checks++; if (LookupHit1 !== 1'b1 || LookupData1 !== 32'd9) begin n_errors++; $display("FAIL fwd_youngest: got hit=%0b data=%0d expected hit=1 data=9", LookupHit1, LookupData1); end
    n_checks++; if (LookupHit2 !== 1'b0 || LookupData2 !== '0) begin n_errors++; $display("FAIL fwd_miss: got hit=%0b data=%0d expected hit=0 data=0", LookupHit2, LookupData2); end
    LookupReg2 = 5'd5;
    #1;
    n_checks++; if (LookupHit2 !== 1'b1 || LookupData2 !== 32'd9) begin n_errors++; $display("FAIL fwd_same_reg: got hit=%0b data=%0d expected hit=1 data=9", LookupHit2, LookupData2); end
    InValid = 1; InRegister = 5'd0; InData = 32'd55;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_errors++; $display("FAIL fwd_r0_ready: got %0b expected 1", InReady); end
    tick();
    InValid = 0; LookupReg1 = 5'd0;
    #1;
    n_checks++; if (LookupHit1 !== 1'b0 || Count !== 3'd2) begin n_errors++; $display("FAIL fwd_r0: got hit=%0b count=%0d expected hit=0 count=2", LookupHit1, Count); end
    Flush = 1; tick(); Flush = 0;
  endtask

  task automatic load_three_plus_output();
    DrainEn = 0;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1; InRegister = 5'(i); InData = 32'(11 * i);
      tick();
    end
    InValid = 0; DrainEn = 1;
    tick();
    DrainEn = 0;
    n_checks++; if (Count !== 3'd3 || RegWrite !== 1'b1) begin n_errors++; $display("FAIL flush_setup: got count=%0d rw=%0b expected count=3 rw=1", Count, RegWrite); end
  endtask

  task automatic test_flush_reset();
    load_three_plus_output();
    Flush = 1; DrainEn = 1; InValid = 1; InRegister = 5'd9; InData = 32'd99;
    tick();
    Flush = 0; DrainEn = 0; InValid = 0; LookupReg1 = 5'd2; LookupReg2 = 5'd1;
    #1;
    n_checks++; if (Count !== '0 || RegWrite !== 1'b0) begin n_errors++; $display("FAIL flush_state: got count=%0d rw=%0b expected count=0 rw=0", Count, RegWrite); end
    n_checks++; if (LookupHit1 !== 1'b0 || LookupHit2 !== 1'b0) begin n_errors++; $display("FAIL flush_lookup: got hit1=%0b hit2=%0b expected 0 0", LookupHit1, LookupHit2); end
    load_three_plus_output();
    Rst_n = 0;
    tick();
    #1;
    n_checks++; if (Count !== '0 || RegWrite !== 1'b0 || WriteData !== '0 || WriteRegister !== '0 || InReady !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid: got count=%0d rw=%0b reg=%0d data=%0d ready=%0b expected all 0", Count, RegWrite, WriteRegister, WriteData, InReady); end
    n_checks++; if (LookupHit1 !== 1'b0 || LookupHit2 !== 1'b0) begin n_errors++; $display("FAIL reset_lookup: got hit1=%0b hit2=%0b expected 0 0", LookupHit1, LookupHit2); end
    Rst_n = 1;
  endtask

  task automatic test_random();
    logic        h1, h2;
    logic [31:0] d1, d2;
    for (int c = 0; c < 600; c++) begin
      Rst_n      = ($urandom_range(0, 63) != 0);
      Flush      = ($urandom_range(0, 31) == 0);
      InValid    = $urandom_range(0, 1);
      InRegister = 5'($urandom_range(0, 7));
      InData     = $urandom;
      DrainEn    = ($urandom_range(0, 9) < 5);
      LookupReg1 = 5'($urandom_range(0, 7));
      LookupReg2 = 5'($urandom_range(0, 7));
      #1;
      model_lookup(LookupReg1, h1, d1);
      model_lookup(LookupReg2, h2, d2);
      n_checks++;
      if (Count !== int'(mq.size()) || RegWrite !== m_rw || (m_rw && (WriteRegister !== m_wr || WriteData !== m_wd))
          || InReady !== ((mq.size() != DEPTH) && Rst_n)) begin
        n_errors++;
        $display("FAIL rand_state cyc %0d: got count=%0d rw=%0b reg=%0d data=%h ready=%0b expected count=%0d rw=%0b reg=%0d data=%h",
                 c, Count, RegWrite, WriteRegister, WriteData, InReady, mq.size(), m_rw, m_wr, m_wd);
      end
      n_checks++;
      if (LookupHit1 !== h1 || LookupData1 !== d1 || LookupHit2 !== h2 || LookupData2 !== d2) begin
        n_errors++;
        $display("FAIL rand_lookup cyc %0d: got %0b/%h %0b/%h expected %0b/%h %0b/%h",
                 c, LookupHit1, LookupData1, LookupHit2, LookupData2, h1, d1, h2, d2);
      end
      tick();
    end
    Rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    foreach (rf[i]) rf[i] = '0;
    mq.delete();
    m_rw = 0; m_wr = '0; m_wd = '0;
    Rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_fill_backpressure();
    test_forwarding();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
